snapshot_free_list: RTL and testbench

- Physical-slot allocator sitting directly upstream of the register file. It hands out free register indices to the rename/dispatch stage, which uses them as register-file write addresses.
- Reclaims indices on commit and tracks the free set as a bitmask.
- Keeps per-branch snapshots of the free set so speculation can roll back in one cycle.
- Feeds a register file of NSLOTS entries; alloc_index drives that file's write/read address space.

---
 rtl/snapshot_free_list_pkg.sv | 17 +
 rtl/snapshot_free_list_lowest_one_encoder.sv | 18 +
 rtl/snapshot_free_list.sv | 67 ++++++
 tb/tb_snapshot_free_list.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snapshot_free_list_pkg.sv
// Shared defaults and types for the snapshot free-list allocator.
package snapshot_free_list_pkg;
  localparam int NSLOTS_DEF     = 8;
  localparam int NSNAPSHOTS_DEF = 2;
  localparam int IDXW_DEF       = $clog2(NSLOTS_DEF);
  localparam int SIDW_DEF       = (NSNAPSHOTS_DEF > 1) ? $clog2(NSNAPSHOTS_DEF) : 1;
  localparam int CNTW_DEF       = $clog2(NSLOTS_DEF + 1);

  typedef logic [IDXW_DEF-1:0]   slot_idx_t;
  typedef logic [SIDW_DEF-1:0]   snap_id_t;
  typedef logic [NSLOTS_DEF-1:0] free_mask_t;

  // A single snapshot entry still needs a one-bit id port.
  function automatic int snap_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/snapshot_free_list_lowest_one_encoder.sv
// Priority encoder: reports whether any bit is set and the lowest set position.
module lowest_one_encoder #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  bits,
  output logic          valid,
  output logic [IW-1:0] index
);
  always_comb begin
    valid = |bits;
    index = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) index = IW'(i);
    end
  end
endmodule

// File: rtl/snapshot_free_list.sv
// Physical slot allocator with per-branch snapshots of the free set for one-cycle rollback.
module snapshot_free_list
  import snapshot_free_list_pkg::*;
#(
  parameter int NSLOTS     = NSLOTS_DEF,
  parameter int NSNAPSHOTS = NSNAPSHOTS_DEF,
  parameter int IDXW       = $clog2(NSLOTS),
  parameter int SIDW       = snap_id_width(NSNAPSHOTS),
  parameter int CNTW       = $clog2(NSLOTS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc_call,
  output logic            alloc_rdy,
  output logic [IDXW-1:0] alloc_index,
  input  logic            free_call,
  input  logic [IDXW-1:0] free_index,
  input  logic            snap_call,
  input  logic [SIDW-1:0] snap_id,
  input  logic            restore_call,
  input  logic [SIDW-1:0] restore_id,
  output logic [CNTW-1:0] free_count
);
  logic [NSLOTS-1:0] free_mask;
  logic [NSLOTS-1:0] snap [NSNAPSHOTS];
  logic [NSLOTS-1:0] base;
  logic [NSLOTS-1:0] free_bits;

  lowest_one_encoder #(.N(NSLOTS), .IW(IDXW)) u_alloc_enc (
    .bits  (free_mask),
    .valid (alloc_rdy),
    .index (alloc_index)
  );

  always_comb begin
    free_count = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      free_count = free_count + CNTW'(free_mask[i]);
    end
  end

  always_comb begin
    free_bits = '0;
    if (free_call) free_bits[free_index] = 1'b1;
  end

  // A restore squashes the same-cycle alloc; a free is committed and always lands.
  always_comb begin
    base = restore_call ? snap[restore_id] : free_mask;
    if (alloc_call && !restore_call && alloc_rdy) base[alloc_index] = 1'b0;
    base = base | free_bits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_mask <= '1;
      for (int k = 0; k < NSNAPSHOTS; k++) snap[k] <= '1;
    end else begin
      free_mask <= base;
      // Committed frees propagate into every snapshot so a later rollback keeps them.
      for (int k = 0; k < NSNAPSHOTS; k++) begin
        if (snap_call && (snap_id == SIDW'(k))) snap[k] <= base;
        else                                    snap[k] <= snap[k] | free_bits;
      end
    end
  end
endmodule

// File: tb/tb_snapshot_free_list.sv
// Directed and randomized checks of snapshot_free_list against a slot-array reference model.
module tb_snapshot_free_list;
  localparam int NS   = 8;
  localparam int NSN  = 2;
  localparam int IDXW = 3;
  localparam int SIDW = 1;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            alloc_call = 1'b0;
  logic            alloc_rdy;
  logic [IDXW-1:0] alloc_index;
  logic            free_call = 1'b0;
  logic [IDXW-1:0] free_index = '0;
  logic            snap_call = 1'b0;
  logic [SIDW-1:0] snap_id = '0;
  logic            restore_call = 1'b0;
  logic [SIDW-1:0] restore_id = '0;
  logic [CNTW-1:0] free_count;

  int checks = 0;
  int errors = 0;

  // Reference model: one bit per slot, true = free.
  bit m_free [NS];
  bit m_snap [NSN][NS];

  snapshot_free_list #(.NSLOTS(NS), .NSNAPSHOTS(NSN)) dut (
    .clk(clk), .reset(reset), .alloc_call(alloc_call), .alloc_rdy(alloc_rdy),
    .alloc_index(alloc_index), .free_call(free_call), .free_index(free_index),
    .snap_call(snap_call), .snap_id(snap_id), .restore_call(restore_call),
    .restore_id(restore_id), .free_count(free_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && alloc_call && !alloc_rdy) begin
      errors++;
      $display("FAIL illegal_alloc: alloc_call issued while alloc_rdy=%0b", alloc_rdy);
    end
  end

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NS; i++) c += m_free[i];
    return c;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NS; i++) if (m_free[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_free[i] = 1'b1;
      for (int k = 0; k < NSN; k++) m_snap[k][i] = 1'b1;
    end
  endtask

  task automatic model_step(input bit a, input bit f, input int fi,
                            input bit s, input int si, input bit r, input int ri);
    bit nxt [NS];
    int taken = m_lowest();
    bit any = (m_count() > 0);
    for (int i = 0; i < NS; i++) nxt[i] = r ? m_snap[ri][i] : m_free[i];
    if (a && !r && any) nxt[taken] = 1'b0;
    if (f) nxt[fi] = 1'b1;
    for (int k = 0; k < NSN; k++) if (f) m_snap[k][fi] = 1'b1;
    if (s) for (int i = 0; i < NS; i++) m_snap[si][i] = nxt[i];
    for (int i = 0; i < NS; i++) m_free[i] = nxt[i];
  endtask

  task automatic step(input bit a, input bit f, input int fi,
                      input bit s, input int si, input bit r, input int ri);
    alloc_call = a; free_call = f; free_index = IDXW'(fi);
    snap_call = s; snap_id = SIDW'(si); restore_call = r; restore_id = SIDW'(ri);
    if (f && m_free[fi] && !r) begin
      errors++;
      $display("FAIL double_free: slot %0d freed while already free", fi);
    end
    @(posedge clk);
    model_step(a, f, fi, s, si, r, ri);
    #1;
    alloc_call = 0; free_call = 0; snap_call = 0; restore_call = 0;
  endtask

  task automatic do_reset(input bit a, input bit s, input bit r);
    reset = 1'b1; alloc_call = a; snap_call = s; restore_call = r;
    snap_id = 1; restore_id = 0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0; alloc_call = 0; snap_call = 0; restore_call = 0;
  endtask

  task automatic test_reset();
    do_reset(0, 0, 0);
    checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b want 1", alloc_rdy); end
    checks++; if (alloc_index !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", alloc_index); end
    checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_count: got %0d want 8", free_count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < NS; i++) begin
      checks++;
      if (alloc_index !== IDXW'(i) || free_count !== CNTW'(NS - i)) begin
        errors++;
        $display("FAIL drain_%0d: idx %0d cnt %0d want idx %0d cnt %0d", i, alloc_index, free_count, i, NS - i);
      end
      step(1, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (alloc_rdy !== 1'b0 || alloc_index !== 3'd0 || free_count !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty: rdy %0b idx %0d cnt %0d want 0 0 0", alloc_rdy, alloc_index, free_count);
    end
  endtask

  task automatic test_free_after_drain();
    step(0, 1, 5, 0, 0, 0, 0);
    checks++;
    if (alloc_rdy !== 1'b1 || alloc_index !== 3'd5 || free_count !== 4'd1) begin
      errors++;
      $display("FAIL free_after_drain: rdy %0b idx %0d cnt %0d want 1 5 1", alloc_rdy, alloc_index, free_count);
    end
  endtask

  task automatic test_alloc_free_same();
    do_reset(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    checks++;
    if (alloc_index !== 3'd1 || free_count !== 4'd4) begin
      errors++;
      $display("FAIL alloc_free_same: idx %0d cnt %0d want 1 4", alloc_index, free_count);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (alloc_index !== 3'd5 || free_count !== 4'd3) begin
      errors++;
      $display("FAIL alloc_free_next: idx %0d cnt %0d want 5 3", alloc_index, free_count);
    end
  endtask

  task automatic test_snap_restore();
    do_reset(0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);   // snap[1] = 11111000
    step(1, 0, 0, 0, 0, 0, 0);   // takes 3
    step(0, 1, 0, 0, 0, 0, 0);   // free 0
    step(0, 0, 0, 0, 0, 1, 1);   // restore -> 11111001
    checks++;
    if (alloc_index !== 3'd0 || free_count !== 4'd6) begin
      errors++;
      $display("FAIL snap_restore: idx %0d cnt %0d want 0 6", alloc_index, free_count);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (alloc_index !== 3'd3 || free_count !== 4'd5) begin
      errors++;
      $display("FAIL snap_restore_next: idx %0d cnt %0d want 3 5", alloc_index, free_count);
    end
  endtask

  task automatic test_restore_drop();
    do_reset(0, 0, 0);
    for (int i = 0; i < NS; i++) step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, i, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);   // snap[0] = 00001111
    step(0, 0, 0, 1, 1, 0, 0);   // snap[1] = 00001111
    step(1, 0, 0, 0, 0, 0, 0);   // mask 00001110
    step(1, 1, 6, 0, 0, 1, 0);   // restore 0 + dropped alloc + free 6
    checks++;
    if (alloc_index !== 3'd0 || free_count !== 4'd5) begin
      errors++;
      $display("FAIL restore_drop: idx %0d cnt %0d want 0 5", alloc_index, free_count);
    end
    step(1, 0, 0, 0, 0, 0, 0);   // mask 01001110
    step(0, 0, 0, 0, 0, 1, 1);   // snap[1] must carry the committed free of 6
    checks++;
    if (alloc_index !== 3'd0 || free_count !== 4'd5) begin
      errors++;
      $display("FAIL snap1_bit6: idx %0d cnt %0d want 0 5", alloc_index, free_count);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (alloc_rdy !== 1'b0 || free_count !== 4'd0) begin
      errors++;
      $display("FAIL snap1_drain: rdy %0b cnt %0d want 0 0", alloc_rdy, free_count);
    end
  endtask

  task automatic test_reset_override();
    step(0, 1, 2, 1, 0, 0, 0);   // snap[0] gets a partially allocated mask
    do_reset(1, 1, 1);
    checks++;
    if (alloc_rdy !== 1'b1 || alloc_index !== 3'd0 || free_count !== 4'd8) begin
      errors++;
      $display("FAIL reset_override: rdy %0b idx %0d cnt %0d want 1 0 8", alloc_rdy, alloc_index, free_count);
    end
    for (int k = 0; k < NSN; k++) begin
      step(0, 0, 0, 0, 0, 1, k);
      checks++;
      if (free_count !== 4'd8) begin
        errors++;
        $display("FAIL reset_snap_%0d: cnt %0d want 8", k, free_count);
      end
    end
  endtask

  task automatic test_random();
    int fi, busy_n;
    bit a, f, s, r;
    int busy [$];
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      end else begin
        busy.delete();
        for (int i = 0; i < NS; i++) if (!m_free[i]) busy.push_back(i);
        busy_n = busy.size();
        a = (m_count() > 0) && ($urandom_range(0, 99) < 55);
        f = (busy_n > 0) && ($urandom_range(0, 99) < 45);
        fi = f ? busy[$urandom_range(0, busy_n - 1)] : 0;
        s = ($urandom_range(0, 99) < 15);
        r = ($urandom_range(0, 99) < 10);
        step(a, f, fi, s, $urandom_range(0, NSN - 1), r, $urandom_range(0, NSN - 1));
      end
      checks++;
      if (alloc_rdy !== (m_count() > 0) || alloc_index !== IDXW'(m_lowest()) ||
          free_count !== CNTW'(m_count())) begin
        errors++;
        $display("FAIL random_%0d: rdy %0b idx %0d cnt %0d want %0b %0d %0d", n, alloc_rdy,
                 alloc_index, free_count, m_count() > 0, m_lowest(), m_count());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_drain();
    test_free_after_drain();
    test_alloc_free_same();
    test_snap_restore();
    test_restore_drop();
    test_reset_override();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
